// File: rtl/rtc_bus_scheduler_if.sv
// RTC bus scheduler signal bundle.
// master: scheduler side; slave: requesters plus timing generator.
interface rtc_bus_scheduler_if;
   logic       wr_req;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_ack;
   logic       tick;
   logic       en_esc;
   logic       en_lect;
   logic       dir_phase;
   logic       dat_lect;
   logic       cambio_est;
   logic [7:0] bus_out;
   logic [7:0] bus_in;
   logic [7:0] rd_data;
   logic [2:0] rd_idx;
   logic       rd_valid;
   logic       burst_done;
   logic       busy;
   logic       err;

   modport master (
      input  wr_req, wr_addr, wr_data, tick,
      input  dir_phase, dat_lect, cambio_est, bus_in,
      output wr_ack, en_esc, en_lect, bus_out,
      output rd_data, rd_idx, rd_valid, burst_done,
      output busy, err
   );

   modport slave (
      output wr_req, wr_addr, wr_data, tick,
      output dir_phase, dat_lect, cambio_est, bus_in,
      input  wr_ack, en_esc, en_lect, bus_out,
      input  rd_data, rd_idx, rd_valid, burst_done,
      input  busy, err
   );
endinterface

// File: rtl/rtc_bus_scheduler.sv
// Shares the RTC A/D bus timing generator between user writes and periodic read bursts.
// Optional watchdog: define RTC_SCHED_TIMEOUT_EN.
module rtc_bus_scheduler #(
   parameter logic [7:0] RD_BASE   = 8'h21,
   parameter int         NUM_RD    = 6,
   parameter int         GAP_CYC   = 2,
   parameter int         TO_CYCLES = 64
) (
   input logic             clk,
   input logic             reset,
   rtc_bus_scheduler_if.master bus
);

   localparam int         GW   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [2:0] LAST = 3'(NUM_RD - 1);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ,
      GAP
   } state_t;

   state_t         state;
   logic [7:0]     addr_q;
   logic [7:0]     data_q;
   logic [7:0]     cap_q;
   logic [2:0]     idx;
   logic           burst_act;
   logic           pend;
   logic           cambio_q;
   logic [GW-1:0]  gap_cnt;
   logic           done_edge;
   logic           to_hit;
   logic [2:0]     rd_next;

   // completion is the first high cycle of cambio_est only
   assign done_edge = bus.cambio_est & ~cambio_q;
   assign rd_next   = burst_act ? idx : 3'd0;
   assign bus.bus_out = bus.dir_phase ? addr_q : data_q;

`ifdef RTC_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TO_CYCLES + 1);
   logic [TW-1:0] to_cnt;

   assign to_hit = (to_cnt == TW'(TO_CYCLES - 1));

   // count cycles spent with an enable raised
   always_ff @(posedge clk) begin
      if (reset || !(state == WRITE || state == READ))
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + 1'b1;
   end
`else
   assign to_hit = 1'b0;
`endif

   // scheduler FSM with registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         addr_q         <= 8'h00;
         data_q         <= 8'h00;
         cap_q          <= 8'h00;
         idx            <= 3'd0;
         burst_act      <= 1'b0;
         pend           <= 1'b0;
         cambio_q       <= 1'b0;
         gap_cnt        <= '0;
         bus.en_esc     <= 1'b0;
         bus.en_lect    <= 1'b0;
         bus.wr_ack     <= 1'b0;
         bus.rd_valid   <= 1'b0;
         bus.burst_done <= 1'b0;
         bus.rd_data    <= 8'h00;
         bus.rd_idx     <= 3'd0;
         bus.busy       <= 1'b0;
         bus.err        <= 1'b0;
      end else begin
         cambio_q       <= bus.cambio_est;
         bus.wr_ack     <= 1'b0;
         bus.rd_valid   <= 1'b0;
         bus.burst_done <= 1'b0;
         pend           <= pend | bus.tick;
         unique case (state)
            IDLE: begin
               if (bus.wr_req) begin
                  state      <= WRITE;
                  bus.busy   <= 1'b1;
                  bus.en_esc <= 1'b1;
                  addr_q     <= bus.wr_addr;
                  data_q     <= bus.wr_data;
               end else if (burst_act || pend) begin
                  state       <= READ;
                  bus.busy    <= 1'b1;
                  bus.en_lect <= 1'b1;
                  addr_q      <= RD_BASE + {5'd0, rd_next};
                  data_q      <= 8'h00;
                  cap_q       <= 8'h00;
                  idx         <= rd_next;
                  if (!burst_act) begin
                     burst_act <= 1'b1;
                     pend      <= bus.tick;
                  end
               end
            end
            WRITE: begin
               if (done_edge) begin
                  bus.wr_ack <= 1'b1;
                  bus.en_esc <= 1'b0;
                  state      <= GAP;
                  gap_cnt    <= '0;
               end else if (to_hit) begin
                  bus.en_esc <= 1'b0;
                  bus.err    <= 1'b1;
                  state      <= GAP;
                  gap_cnt    <= '0;
               end
            end
            READ: begin
               if (bus.dat_lect)
                  cap_q <= bus.bus_in;
               if (done_edge) begin
                  bus.rd_data  <= bus.dat_lect ? bus.bus_in : cap_q;
                  bus.rd_idx   <= idx;
                  bus.rd_valid <= 1'b1;
                  bus.en_lect  <= 1'b0;
                  state        <= GAP;
                  gap_cnt      <= '0;
                  if (idx == LAST) begin
                     bus.burst_done <= 1'b1;
                     burst_act      <= 1'b0;
                     idx            <= 3'd0;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end else if (to_hit) begin
                  bus.en_lect <= 1'b0;
                  bus.err     <= 1'b1;
                  burst_act   <= 1'b0;
                  idx         <= 3'd0;
                  state       <= GAP;
                  gap_cnt     <= '0;
               end
            end
            GAP: begin
               if (gap_cnt == GW'(GAP_CYC - 1)) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
